// File: rtl/ysyx_20020207_pkg.sv
// Shared constants and types for the ysyx_20020207 instruction fetch unit.
// State codes are fixed 2-bit values so debug probes and checkers can decode them.
package ysyx_20020207_pkg;

  localparam logic [1:0] S_REQ_CODE  = 2'd0;
  localparam logic [1:0] S_WAIT_CODE = 2'd1;
  localparam logic [1:0] S_HOLD_CODE = 2'd2;
  localparam logic [1:0] S_DROP_CODE = 2'd3;

  typedef enum logic [1:0] {
    S_REQ  = S_REQ_CODE,
    S_WAIT = S_WAIT_CODE,
    S_HOLD = S_HOLD_CODE,
    S_DROP = S_DROP_CODE
  } state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_20020207_ifu_if.sv
// Bus bundle of the fetch unit: instruction-memory AR/R channels plus the decode-side output.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface ysyx_20020207_ifu_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        fetch_err;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output araddr, arvalid, rready, inst_out, pc_out, fetch_err, out_valid,
    input  arready, rdata, rresp, rvalid, out_ready
  );

  modport slave (
    input  araddr, arvalid, rready, inst_out, pc_out, fetch_err, out_valid,
    output arready, rdata, rresp, rvalid, out_ready
  );
endinterface

// File: rtl/ysyx_20020207_ifu.sv
// Instruction fetch unit: one read at a time, holds each word until decode takes it,
// and a jump restarts fetch at the target while discarding stale responses.
module ysyx_20020207_ifu
  import ysyx_20020207_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 jump,
  input  logic [31:0]          jump_pc,
  ysyx_20020207_ifu_if.master  bus,
  output state_t               dbg_state
);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        latch_en;
  logic [31:0] inst_q, pc_q;
  logic        err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // A jump always retargets pc; its effect on state depends on what is in flight.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    latch_en = 1'b0;
    case (state)
      S_REQ: begin
        if (jump) begin
          pc_n    = jump_pc;
          state_n = bus.arready ? S_DROP : S_REQ;
        end else if (bus.arready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (jump) begin
          pc_n    = jump_pc;
          state_n = bus.rvalid ? S_REQ : S_DROP;
        end else if (bus.rvalid) begin
          latch_en = 1'b1;
          pc_n     = pc + 32'd4;
          state_n  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (jump) begin
          pc_n    = jump_pc;
          state_n = S_REQ;
        end else if (bus.out_ready) begin
          state_n = S_REQ;
        end
      end
      S_DROP: begin
        if (jump) pc_n = jump_pc;
        if (bus.rvalid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inst_q <= 32'd0;
      pc_q   <= 32'd0;
      err_q  <= 1'b0;
    end else if (latch_en) begin
      inst_q <= bus.rdata;
      pc_q   <= pc;
      err_q  <= (bus.rresp != RESP_OKAY);
    end
  end

  // Handshake outputs decode from state only, so no input reaches them combinationally.
  assign bus.arvalid   = (state == S_REQ);
  assign bus.rready    = (state == S_WAIT) || (state == S_DROP);
  assign bus.out_valid = (state == S_HOLD);
  assign bus.araddr    = pc;
  assign bus.inst_out  = inst_q;
  assign bus.pc_out    = pc_q;
  assign bus.fetch_err = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ysyx_20020207_ifu.sv
// Bench for ysyx_20020207_ifu: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (fetch pointer, outstanding read, expected-output queue).
module tb_ysyx_20020207_ifu;
  import ysyx_20020207_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        jump = 1'b0;
  logic [31:0] jump_pc = 32'd0;
  state_t      dbg_state;

  ysyx_20020207_ifu_if bus();

  ysyx_20020207_ifu #(.RESET_PC(RST_PC)) dut (
    .clock     (clock),
    .reset     (reset),
    .jump      (jump),
    .jump_pc   (jump_pc),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: fetch pointer, one outstanding read, expected held outputs
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_req_pc = 32'd0;
  logic        m_out = 1'b0;
  logic        m_stale = 1'b0;
  logic [64:0] exp_q[$];

  // memory responder
  logic        mem_pending = 1'b0;
  int          mem_cnt = 0;
  int          mem_delay = 1;
  logic        use_rand = 1'b0;
  logic [31:0] fixed_data = 32'h0000_0013;
  logic [31:0] err_addr = 32'h0000_0001;
  logic [31:0] pend_data = 32'd0;
  logic [1:0]  pend_resp = 2'b00;

  logic [31:0] ar_log[$];
  int          ar_cyc[$];
  logic [64:0] out_log[$];
  int          dead_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: compare DUT against model, drive inputs, advance model; returns at posedge+1.
  task automatic step(input logic rst, input logic jmp, input logic [31:0] jpc,
                      input logic ardy, input logic ordy);
    logic        rv;
    logic        m_req;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [64:0] head;
    @(negedge clock);
    cyc++;
    if (m_valid) begin
      m_req = !m_out && (exp_q.size() == 0);
      chk("arvalid", 32'(bus.arvalid), 32'(m_req));
      if (m_req) chk("araddr", bus.araddr, m_pc);
      chk("rready", 32'(bus.rready), 32'(m_out));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("ar_r_exclusive", 32'(bus.arvalid & bus.rready), 32'd0);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("inst_out", bus.inst_out, head[31:0]);
        chk("pc_out", bus.pc_out, head[63:32]);
        chk("fetch_err", 32'(bus.fetch_err), 32'(head[64]));
      end
    end
    if (bus.out_valid === 1'b1 && bus.inst_out == 32'hDEAD_BEEF) dead_seen++;

    rv = 1'b0;
    if (!rst && mem_pending) begin
      if (mem_cnt == 0) begin
        rv = 1'b1;
        mem_pending = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    rd = rv ? pend_data : $urandom;
    rr = rv ? pend_resp : 2'($urandom_range(0, 3));
    reset         = rst;
    jump          = jmp;
    jump_pc       = jpc;
    bus.arready   = ardy;
    bus.out_ready = ordy;
    bus.rvalid    = rv;
    bus.rdata     = rd;
    bus.rresp     = rr;

    if (rst) begin
      mem_pending = 1'b0;
    end else if (bus.arvalid === 1'b1 && ardy) begin
      ar_log.push_back(bus.araddr);
      ar_cyc.push_back(cyc);
      mem_pending = 1'b1;
      mem_cnt     = (use_rand ? $urandom_range(1, 4) : mem_delay) - 1;
      pend_data   = use_rand ? $urandom : fixed_data;
      if (bus.araddr == err_addr) pend_resp = 2'b10;
      else if (use_rand && $urandom_range(0, 9) == 0) pend_resp = 2'($urandom_range(1, 3));
      else pend_resp = 2'b00;
    end
    if (!rst && !jmp && bus.out_valid === 1'b1 && ordy)
      out_log.push_back({bus.fetch_err, bus.pc_out, bus.inst_out});

    if (rst) begin
      m_valid = 1'b1;
      m_pc    = RST_PC;
      m_out   = 1'b0;
      m_stale = 1'b0;
      exp_q.delete();
    end else if (m_valid) begin
      m_req = !m_out && (exp_q.size() == 0);
      if (jmp) begin
        if (exp_q.size() != 0) exp_q.delete();
        else if (m_out) begin
          if (rv) m_out = 1'b0;
          else m_stale = 1'b1;
        end else if (ardy) begin
          m_out   = 1'b1;
          m_stale = 1'b1;
        end
        m_pc = jpc;
      end else if (m_req && ardy) begin
        m_out    = 1'b1;
        m_stale  = 1'b0;
        m_req_pc = m_pc;
      end else if (m_out && rv) begin
        m_out = 1'b0;
        if (!m_stale) begin
          exp_q.push_back({rr != 2'b00, m_req_pc, rd});
          m_pc = m_req_pc + 32'd4;
        end
      end else if (exp_q.size() != 0 && ordy) begin
        void'(exp_q.pop_front());
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_until_out_valid(input logic ordy, input string name);
    int i;
    i = 0;
    while (bus.out_valid !== 1'b1 && i < 20) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, ordy);
      i++;
    end
    chk({name, "_reach_hold"}, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] held_inst, held_pc;
    logic [64:0] e;
    int          n_before;

    // 1: reset state and back-to-back fetches with a 1-cycle memory
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_arvalid", 32'(bus.arvalid), 32'd1);
    chk("rst_araddr", bus.araddr, 32'h8000_0000);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_pc_out", bus.pc_out, 32'd0);
    ar_log.delete(); ar_cyc.delete(); out_log.delete();
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("seq_ar_count", 32'(ar_log.size()), 32'd3);
    if (ar_log.size() == 3) begin
      chk("seq_araddr0", ar_log[0], 32'h8000_0000);
      chk("seq_araddr1", ar_log[1], 32'h8000_0004);
      chk("seq_araddr2", ar_log[2], 32'h8000_0008);
      chk("seq_period", 32'(ar_cyc[1] - ar_cyc[0]), 32'd3);
    end
    chk("seq_out_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() >= 2) begin
      e = out_log[1];
      chk("seq_out_pc1", e[63:32], 32'h8000_0004);
      chk("seq_out_inst1", e[31:0], 32'h0000_0013);
    end

    // 2: decode stalls for 5 cycles in hold
    run_until_out_valid(1'b0, "stall");
    held_inst = bus.inst_out;
    held_pc   = bus.pc_out;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      chk("stall_arvalid", 32'(bus.arvalid), 32'd0);
      chk("stall_pc_out", bus.pc_out, held_pc);
      chk("stall_inst_out", bus.inst_out, held_inst);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("stall_release_arvalid", 32'(bus.arvalid), 32'd1);

    // 3: jump during wait; the slow DEADBEEF response must vanish
    dead_seen  = 0;
    mem_delay  = 3;
    fixed_data = 32'hDEAD_BEEF;
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b1);
    mem_delay  = 1;
    fixed_data = 32'h0000_0013;
    for (int i = 0; i < 10 && bus.arvalid !== 1'b1; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("jw_arvalid", 32'(bus.arvalid), 32'd1);
    chk("jw_araddr", bus.araddr, 32'h8000_0100);
    run_until_out_valid(1'b0, "jw");
    chk("jw_pc_out", bus.pc_out, 32'h8000_0100);
    chk("jw_inst_out", bus.inst_out, 32'h0000_0013);
    chk("jw_deadbeef_presented", 32'(dead_seen), 32'd0);

    // 4: jump in hold with out_ready=1 loses the held word
    n_before = out_log.size();
    step(1'b0, 1'b1, 32'h8000_0200, 1'b0, 1'b1);
    chk("jh_out_valid", 32'(bus.out_valid), 32'd0);
    chk("jh_arvalid", 32'(bus.arvalid), 32'd1);
    chk("jh_araddr", bus.araddr, 32'h8000_0200);
    chk("jh_no_transfer", 32'(out_log.size()), 32'(n_before));

    // 5: error response at 8000_0008, next fetch clean
    err_addr = 32'h8000_0008;
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    out_log.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("err_out_count", 32'(out_log.size()), 32'd4);
    if (out_log.size() >= 4) begin
      e = out_log[2];
      chk("err_pc", e[63:32], 32'h8000_0008);
      chk("err_flag", 32'(e[64]), 32'd1);
      e = out_log[3];
      chk("err_next_pc", e[63:32], 32'h8000_000C);
      chk("err_next_flag", 32'(e[64]), 32'd0);
    end
    err_addr = 32'h0000_0001;

    // 6: pc wraps from FFFF_FFFC to 0
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    for (int i = 0; i < 10 && bus.arvalid !== 1'b1; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("wrap_araddr_pre", bus.araddr, 32'hFFFF_FFFC);
    run_until_out_valid(1'b0, "wrap");
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("wrap_araddr", bus.araddr, 32'h0000_0000);

    // 7: reset in drop and in hold
    mem_delay = 3;
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h8000_0300, 1'b0, 1'b1);
    chk("drop_state", 32'(dbg_state), 32'(S_DROP_CODE));
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rd_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_arvalid", 32'(bus.arvalid), 32'd1);
    chk("rd_araddr", bus.araddr, RST_PC);
    mem_delay = 1;
    run_until_out_valid(1'b0, "rh");
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("rh_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rh_arvalid", 32'(bus.arvalid), 32'd1);
    chk("rh_araddr", bus.araddr, RST_PC);

    // 8: random traffic
    use_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_20020207_ifu.md
# ysyx_20020207_ifu

Instruction fetch unit: the producer for the decode stage's `inst`/`pc`/`valid` input. Maintains the fetch PC, issues one read per instruction on a valid/ready instruction-memory bus (AR/R channel pair), and holds each fetched word until decode accepts it. A redirect from execute (`jump`, `jump_pc`) restarts fetch at the target and discards any stale in-flight or held instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.

Ports:
- `clock` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `jump` in 1: redirect request, single-cycle pulse.
- `jump_pc` in 32: redirect target; sampled when `jump`=1.
- `araddr` out 32: fetch address.
- `arvalid` out 1: read request valid.
- `arready` in 1: memory accepts request.
- `rdata` in 32: instruction word.
- `rresp` in 2: response code; 2'b00 = OKAY.
- `rvalid` in 1: response valid.
- `rready` out 1: IFU accepts response.
- `inst_out` out 32: instruction to decode.
- `pc_out` out 32: PC of `inst_out`.
- `fetch_err` out 1: `inst_out` came from a non-OKAY response; qualified by `out_valid`.
- `out_valid` out 1: `inst_out`/`pc_out`/`fetch_err` valid.
- `out_ready` in 1: decode accepts; transfer when `out_valid && out_ready`.

## Operation
- State machine: S_REQ, S_WAIT, S_HOLD, S_DROP. Internal `pc` register.
- S_REQ: `arvalid`=1, `araddr`=`pc`. If `arvalid && arready`, go to S_WAIT.
- S_WAIT: `rready`=1. If `rvalid`:
  - latch `inst_out`←`rdata`, `pc_out`←`pc`, `fetch_err`←(`rresp`!=0);
  - set `pc`←`pc`+4 (mod 2^32, wraps 32'hFFFF_FFFC→0);
  - go to S_HOLD.
- S_HOLD: `out_valid`=1; outputs stable. On `out_ready`, go to S_REQ.
- S_DROP: `rready`=1. On `rvalid`, discard data and go to S_REQ. Issues no new request.
- Redirect: `jump` has priority over every other event in the same cycle and always sets `pc`←`jump_pc`.
  - S_REQ without AR handshake: stay in S_REQ; `araddr` shows the new `pc` next cycle. Changing the address before the handshake is legal on this bus.
  - S_REQ with AR handshake the same cycle: go to S_DROP.
  - S_WAIT without `rvalid`: go to S_DROP.
  - S_WAIT with `rvalid`: discard the response and go to S_REQ.
  - S_HOLD: clear `out_valid` and go to S_REQ. The held instruction is lost, even if `out_ready`=1 that cycle (decode flushes on `jump` as well).
  - S_DROP: stay in S_DROP. If `rvalid` arrives the same cycle, go to S_REQ.
- `jump_pc` is not alignment-checked; bits [1:0] pass through to `araddr`.
- At most one outstanding read. `arvalid` and `rready` are never both 1.

## Timing
- Reset values: state S_REQ, `pc`=`RESET_PC`, `out_valid`=0, `inst_out`=0, `pc_out`=0, `fetch_err`=0. `arvalid`=1 and `araddr`=`RESET_PC` from the first cycle after reset deasserts.
- Reset mid-operation returns to S_REQ regardless of state. The memory side is reset by the same signal, so no response is drained.
- `arvalid`, `rready` and `out_valid` decode directly from state; no combinational path from inputs.
- Minimum latency: AR handshake in cycle 0, `rvalid` in cycle 1, `out_valid` in cycle 2. With `out_ready` held at 1, the next `arvalid` comes in cycle 3, so peak throughput is 1 instruction per 3 cycles.
- Redirect to visible `araddr`=`jump_pc`: 1 cycle from S_REQ/S_HOLD/S_WAIT+`rvalid`. From S_DROP it is 1 cycle after the dropped `rvalid`.

## Structure
- Shared package `ysyx_20020207_pkg`:
  - state encoding (2-bit localparams S_REQ/S_WAIT/S_HOLD/S_DROP);
  - `RESP_OKAY`=2'b00;
  - default reset PC constant.
- Single flat module: one state register, `pc`, and the output latch. No sub-module.

## Test plan
- Reset, memory with `arready`=1 and 1-cycle `rvalid` returning 32'h00000013: `araddr` 8000_0000, 8000_0004, 8000_0008 in sequence; `out_valid` every 3rd cycle with matching `pc_out`.
- `out_ready`=0 for 5 cycles in S_HOLD: `inst_out`/`pc_out` stable, `arvalid`=0 throughout; the next fetch is issued the cycle after `out_ready`=1.
- `jump`=1, `jump_pc`=8000_0100 during S_WAIT with `rvalid` 3 cycles later carrying 32'hDEADBEEF: that word is never presented; the next `araddr`=8000_0100 and `out_valid` shows `pc_out`=8000_0100.
- `jump` in S_HOLD coincident with `out_ready`=1: `out_valid` drops next cycle; `araddr`=`jump_pc`.
- `rresp`=2'b10 on fetch at 8000_0008: `out_valid`=1 with `fetch_err`=1 and `pc_out`=8000_0008; the following fetch has `fetch_err`=0.
- `reset` asserted in S_DROP and in S_HOLD: next cycle `out_valid`=0, `arvalid`=1, `araddr`=`RESET_PC`.
